// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} div_state_t;

   localparam int DIV_WIDTH_DEFAULT = 16;

   // Step counter width; must hold WIDTH-1.
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// Start/done handshake and result bus of the divider; slave side is the divider.
interface div_seq_if #(parameter int WIDTH = div_pkg::DIV_WIDTH_DEFAULT);

   logic             start_i;
   logic             signed_i;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] quotient_o;
   logic [WIDTH-1:0] remainder_o;
   logic             div_by_zero_o;

   modport master (
      output start_i, signed_i, dividend_i, divisor_i,
      input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
   );

   modport slave (
      input  start_i, signed_i, dividend_i, divisor_i,
      output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
   );

endinterface

// File: rtl/div_seq_step.sv
// One restoring-division row: trial subtract with borrow, then keep or restore.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   logic [WIDTH+1:0] diff;
   logic             borrow;
   logic             diff_unused;

   assign diff   = {1'b0, rem_i} - {2'b00, div_i};
   assign borrow = diff[WIDTH+1];
   assign q_o    = ~borrow;
   // Without a borrow the difference is below the divisor, so its top bit is zero.
   assign diff_unused = diff[WIDTH];
   assign rem_o  = borrow ? rem_i[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned restoring divider, one quotient bit per clock.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   div_seq_if.slave  bus
);

   localparam int CW = cnt_w(WIDTH);

   div_state_t       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, dvd_q, dvs_q;
   logic [WIDTH-1:0] quo_o_q, rem_o_q;
   logic             q_neg_q, r_neg_q, dz_q, dz_o_q, busy_q, done_q;

   logic [WIDTH-1:0] rem_d;
   logic             qbit_d;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   // MIN negates to itself, which is exactly its unsigned magnitude.
   always_comb begin
      a_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
      b_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
      a_mag = a_neg ? -bus.dividend_i : bus.dividend_i;
      b_mag = b_neg ? -bus.divisor_i  : bus.divisor_i;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i ({rem_q, dvd_q[WIDTH-1]}),
      .div_i (dvs_q),
      .rem_o (rem_d),
      .q_o   (qbit_d)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_o_q <= '0;
         rem_o_q <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dz_q    <= 1'b0;
         dz_o_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               if (bus.start_i) begin
                  busy_q <= 1'b1;
                  cnt_q  <= CW'(WIDTH - 1);
                  if (bus.divisor_i == '0) begin
                     // Preload the zero-divisor result so FIX handles it like any other.
                     state_q <= S_FIX;
                     dz_q    <= 1'b1;
                     rem_q   <= bus.dividend_i;
                     dvd_q   <= '1;
                     dvs_q   <= '0;
                     q_neg_q <= 1'b0;
                     r_neg_q <= 1'b0;
                  end else begin
                     state_q <= S_CALC;
                     dz_q    <= 1'b0;
                     rem_q   <= '0;
                     dvd_q   <= a_mag;
                     dvs_q   <= b_mag;
                     q_neg_q <= a_neg ^ b_neg;
                     r_neg_q <= a_neg;
                  end
               end
            end
            S_CALC: begin
               rem_q <= rem_d;
               dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= S_FIX;
            end
            S_FIX: begin
               quo_o_q <= q_neg_q ? -dvd_q : dvd_q;
               rem_o_q <= r_neg_q ? -rem_q : rem_q;
               dz_o_q  <= dz_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.busy_o        = busy_q;
   assign bus.done_o        = done_q;
   assign bus.quotient_o    = quo_o_q;
   assign bus.remainder_o   = rem_o_q;
   assign bus.div_by_zero_o = dz_o_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq at WIDTH=16 plus a short modelled random sweep.
module tb_div_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   t0 = 0;
   int   lat = 0;
   int   pass_cnt = 0;
   int   tot_cnt = 0;

   div_seq_if #(.WIDTH(16)) bus ();

   div_seq #(.WIDTH(16)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tot_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive one start pulse; t0 records the accepting edge.
   task automatic go(input logic sgn, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.start_i    = 1'b1;
      bus.signed_i   = sgn;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      @(negedge clk);
      bus.start_i = 1'b0;
      t0 = cyc;
   endtask

   // lat counts cycles from the start edge through the done edge inclusive.
   task automatic wait_done(input string tag);
      int n = 0;
      while (bus.done_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      lat = cyc - t0 + 1;
      chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd1);
   endtask

   task automatic res(input string tag, input logic [15:0] q, input logic [15:0] r, input logic dz);
      chk({tag, "_q"},  {16'd0, bus.quotient_o},  {16'd0, q});
      chk({tag, "_r"},  {16'd0, bus.remainder_o}, {16'd0, r});
      chk({tag, "_dz"}, {31'd0, bus.div_by_zero_o}, {31'd0, dz});
   endtask

   function automatic void model(input logic s, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] q, output logic [15:0] r);
      int ai, bi, qi, ri;
      if (b == 16'd0) begin
         q = 16'hFFFF;
         r = a;
         return;
      end
      ai = s ? int'($signed(a)) : int'(a);
      bi = s ? int'($signed(b)) : int'(b);
      qi = ai / bi;
      ri = ai % bi;
      q  = qi[15:0];
      r  = ri[15:0];
   endfunction

   initial begin
      int d0, bc;
      logic [15:0] ra, rb, eq, er;
      logic rs;
      bus.start_i = 1'b0; bus.signed_i = 1'b0;
      bus.dividend_i = '0; bus.divisor_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_q",    {16'd0, bus.quotient_o}, 32'd0);
      chk("rst_r",    {16'd0, bus.remainder_o}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      chk("rst_done", {31'd0, bus.done_o}, 32'd0);
      rst_n = 1'b1;

      // Unsigned basic with busy-length measurement
      go(1'b0, 16'd100, 16'd7);
      bc = 0;
      for (int i = 0; i < 40 && bus.done_o !== 1'b1; i++) begin
         if (bus.busy_o) bc++;
         @(negedge clk);
      end
      lat = cyc - t0 + 1;
      chk("u100_lat", lat, 18);
      chk("u100_busy", bc, 17);
      res("u100", 16'd14, 16'd2, 1'b0);
      @(negedge clk);
      chk("u100_pulse", {31'd0, bus.done_o}, 32'd0);

      go(1'b1, 16'hFFF9, 16'd2);  wait_done("sn7_2");  res("sn7_2", 16'hFFFD, 16'hFFFF, 1'b0);
      go(1'b1, 16'h0007, 16'hFFFE); wait_done("s7_n2"); res("s7_n2", 16'hFFFD, 16'h0001, 1'b0);
      go(1'b1, 16'h8000, 16'hFFFF); wait_done("smin");  res("smin", 16'h8000, 16'h0000, 1'b0);
      go(1'b0, 16'h8000, 16'hFFFF); wait_done("umin");  res("umin", 16'h0000, 16'h8000, 1'b0);
      go(1'b1, 16'hFF9C, 16'hFFF9); wait_done("snn");   res("snn", 16'd14, 16'hFFFE, 1'b0);
      go(1'b0, 16'd5, 16'd9);     wait_done("small");  res("small", 16'd0, 16'd5, 1'b0);

      // Divide by zero, unsigned and signed
      go(1'b0, 16'd1234, 16'd0); wait_done("dz_u");
      chk("dz_u_lat", lat, 2);
      res("dz_u", 16'hFFFF, 16'd1234, 1'b1);
      go(1'b1, 16'hFFFB, 16'd0); wait_done("dz_s"); res("dz_s", 16'hFFFF, 16'hFFFB, 1'b1);
      go(1'b0, 16'd100, 16'd7);  wait_done("dz_clr"); res("dz_clr", 16'd14, 16'd2, 1'b0);

      // Start mid-CALC must be ignored
      go(1'b0, 16'd1000, 16'd3);
      repeat (5) @(negedge clk);
      bus.start_i = 1'b1; bus.dividend_i = 16'd50; bus.divisor_i = 16'd5;
      @(negedge clk);
      bus.start_i = 1'b0;
      wait_done("ign");
      chk("ign_lat", lat, 18);
      res("ign", 16'd333, 16'd1, 1'b0);

      // Start in the DONE cycle
      go(1'b0, 16'd1000, 16'd10); wait_done("b2b_a");
      d0 = cyc;
      bus.start_i = 1'b1; bus.signed_i = 1'b1;
      bus.dividend_i = 16'hFFF0; bus.divisor_i = 16'd3;
      @(negedge clk);
      bus.start_i = 1'b0;
      t0 = cyc;
      chk("b2b_busy", {31'd0, bus.busy_o}, 32'd1);
      chk("b2b_hold", {16'd0, bus.quotient_o}, 32'd100);
      wait_done("b2b_b");
      chk("b2b_gap", cyc - d0, 18);
      res("b2b_b", 16'hFFFB, 16'hFFFF, 1'b0);

      // Reset mid-CALC
      go(1'b0, 16'd100, 16'd7);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      res("rst_mid", 16'd0, 16'd0, 1'b0);
      chk("rst_mid_busy", {31'd0, bus.busy_o}, 32'd0);
      @(negedge clk);
      chk("rst_mid_done", {31'd0, bus.done_o}, 32'd0);
      rst_n = 1'b1;
      go(1'b0, 16'hFFFF, 16'h0001); wait_done("post_rst"); res("post_rst", 16'hFFFF, 16'h0000, 1'b0);

      // Random sweep against the reference model
      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = 16'($urandom);
         rb = (i % 5 == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
         if (i % 7 == 3) rb = 16'hFFFF;
         model(rs, ra, rb, eq, er);
         go(rs, ra, rb);
         wait_done("rnd");
         res("rnd", eq, er, rb == 16'd0);
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/div_seq.md
# div_seq

Parametrised sequential integer divider: the multi-cycle successor to the single-bit `div_core` subtract/select cell. It divides a WIDTH-bit dividend by a WIDTH-bit divisor using restoring division, producing one quotient bit per clock. Each operation runs in either unsigned or signed mode. It sits beside the classifier datapath as a shared arithmetic resource, used for normalisation and averaging, behind a start/done handshake.

## Interface
- `WIDTH`, 16: operand, quotient and remainder width; legal range 4..32.
- `clk_i` input 1: single clock, rising edge.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `start_i` input 1: request. It is accepted only in IDLE or DONE.
- `signed_i` input 1: 1 selects two's-complement mode. Sampled with `start_i`.
- `dividend_i` input WIDTH: sampled on the accepting edge.
- `divisor_i` input WIDTH: sampled on the accepting edge.
- `busy_o` output 1: high in CALC and FIX.
- `done_o` output 1: one-cycle pulse; results are valid from this cycle on.
- `quotient_o` output WIDTH: registered quotient.
- `remainder_o` output WIDTH: registered remainder.
- `div_by_zero_o` output 1: registered; describes the most recent result.

## Operation
- **FSM states:**
  - IDLE –(start_i)→ CALC, or → FIX when divisor_i == 0.
  - CALC: stays WIDTH cycles, then → FIX.
  - FIX: → DONE.
  - DONE: → IDLE, or → CALC/FIX when start_i is high in that cycle.
- **Accept edge:**
  - Latch the operand magnitudes into the working registers. In signed mode, negative operands are negated; the most-negative value is kept as its unsigned pattern.
  - Latch the result signs: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend). Both are 0 in unsigned mode.
  - Load the step counter with WIDTH-1.
- **CALC step** (one per cycle):
  - Shift the {partial remainder, dividend} pair left by one.
  - Trial-subtract the divisor at WIDTH+1 bits.
  - If there is no borrow, keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Decrement the counter.
- **FIX:**
  - Apply sign correction: negate the quotient if q_neg, negate the remainder if r_neg.
  - Write `quotient_o`, `remainder_o` and `div_by_zero_o`.
- **Divide by zero:**
  - quotient_o = all ones. This is 2^WIDTH−1 unsigned, or −1 signed.
  - remainder_o = dividend_i unmodified.
  - div_by_zero_o = 1.
- **Signed overflow** (MIN / −1): quotient_o = MIN, remainder_o = 0, div_by_zero_o = 0. This falls out of the magnitude arithmetic; no special case is needed.
- Signed results truncate toward zero. The remainder takes the sign of the dividend.
- `start_i` while busy_o = 1 is ignored. The operation in flight is not disturbed.
- `start_i` in the DONE cycle is accepted, giving back-to-back operation with no idle cycle.
- Result registers hold their value until the FIX of the next operation.

## Timing
- **Reset** (asynchronous, any state, including mid-CALC):
  - State returns to IDLE.
  - busy_o = 0, done_o = 0.
  - quotient_o = 0, remainder_o = 0, div_by_zero_o = 0.
  - Counter and working registers are cleared.
- **Normal operation:**
  - Start sampled at edge 0; busy_o is high after edges 0..WIDTH.
  - done_o is high after edge WIDTH+1, for exactly one cycle.
  - Total latency is WIDTH+2 cycles (18 for WIDTH = 16).
- **Zero divisor:**
  - Start at edge 0; FIX after edge 0; done_o high after edge 1.
  - Latency is 2 cycles.
- **Throughput:** one result every WIDTH+2 cycles with back-to-back starts.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Structure
- **Package `div_pkg`:**
  - `div_state_t` enum (IDLE, CALC, FIX, DONE).
  - `DIV_WIDTH_DEFAULT` = 16.
  - Counter width function `$clog2(WIDTH)`.
- **Sub-module `div_step`:**
  - Parametrised WIDTH+1-bit subtract-with-borrow and select row. It is the row generalisation of the bit cell.
  - Inputs: partial remainder, divisor.
  - Outputs: next remainder, quotient bit.
  - It is instantiated once in `div_seq` and iterated over time.

## Test plan
- **Unsigned basic** (WIDTH = 16): 100 / 7 → quotient 14, remainder 2, done_o high exactly 18 cycles after the start edge, busy_o high for 17 cycles.
- **Signed mixed signs:**
  - −7 / 2 → quotient −3 (0xFFFD), remainder −1 (0xFFFF).
  - 7 / −2 → quotient −3, remainder 1.
  - 0x8000 / 0xFFFF → quotient 0x8000, remainder 0.
- **Divide by zero:**
  - 1234 / 0 unsigned → quotient 0xFFFF, remainder 1234, div_by_zero_o = 1, done_o 2 cycles after start.
  - The next valid divide clears div_by_zero_o.
- **Handshake:**
  - A start pulse mid-CALC with different operands is ignored; the original result is returned on schedule.
  - A start asserted in the DONE cycle launches the next operation; its done_o arrives 18 cycles later.
- **Reset mid-operation:**
  - Assert rst_n_i = 0 at cycle 8 of CALC → all outputs are 0 immediately, with no done_o.
  - After release, 0xFFFF / 0x0001 gives quotient 0xFFFF, remainder 0.
- **Randomised sweep:** 10k random operands and modes at WIDTH = 8 and 32, checked against a reference model; include a divisor greater than the dividend (expect quotient 0, remainder = dividend).
